// File: rtl/fwrisc_rf_dbg_arb.sv
// fwrisc_rf_dbg_arb: arbitrates debug register-file access against the core, stalling it only while debug owns the regfile.
module fwrisc_rf_dbg_arb #(
  parameter int TIMEOUT = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [5:0]  core_ra_raddr,
  input  logic [5:0]  core_rd_waddr,
  input  logic [31:0] core_rd_wdata,
  input  logic        core_rd_wen,
  input  logic        core_idle,
  output logic        core_stall,
  input  logic        dbg_req_valid,
  output logic        dbg_req_ready,
  input  logic        dbg_req_write,
  input  logic [5:0]  dbg_req_addr,
  input  logic [31:0] dbg_req_wdata,
  output logic        dbg_rsp_valid,
  input  logic        dbg_rsp_ready,
  output logic [31:0] dbg_rsp_rdata,
  output logic        dbg_rsp_err,
  output logic [5:0]  rf_ra_raddr,
  output logic [5:0]  rf_rd_waddr,
  output logic [31:0] rf_rd_wdata,
  output logic        rf_rd_wen,
  input  logic [31:0] rf_ra_rdata
);
  typedef enum logic [2:0] {IDLE, DRAIN, ACCESS, CAPTURE, RESP} state_t;
  localparam logic [15:0] LAST = 16'(TIMEOUT - 1);
  state_t state, state_n;
  logic [15:0] cnt;
  logic        req_write;
  logic [5:0]  req_addr;
  logic [31:0] req_wdata;
  logic        accept, access, timeout;
  assign accept  = dbg_req_valid && dbg_req_ready;
  assign access  = state == ACCESS;
  assign timeout = state == DRAIN && !core_idle && cnt == LAST;
  assign dbg_req_ready = state == IDLE;
  assign dbg_rsp_valid = state == RESP;
  assign core_stall    = state == DRAIN || state == ACCESS || state == CAPTURE;
  assign rf_ra_raddr = access ? req_addr : core_ra_raddr;
  assign rf_rd_waddr = access ? req_addr : core_rd_waddr;
  assign rf_rd_wdata = access ? req_wdata : core_rd_wdata;
  // the debug write is suppressed the moment reset rises, even mid-ACCESS
  assign rf_rd_wen   = access ? (req_write && req_addr != '0 && !reset) : core_rd_wen;
  always_ff @(posedge clock)
    state <= reset ? IDLE : state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = accept ? DRAIN : IDLE;
      DRAIN:   state_n = core_idle ? ACCESS : (timeout ? RESP : DRAIN);
      ACCESS:  state_n = req_write ? RESP : CAPTURE;
      CAPTURE: state_n = RESP;
      RESP:    state_n = dbg_rsp_ready ? IDLE : RESP;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clock)
    if (reset) begin
      cnt           <= '0;
      req_write     <= 1'b0;
      req_addr      <= '0;
      req_wdata     <= '0;
      dbg_rsp_rdata <= '0;
      dbg_rsp_err   <= 1'b0;
    end else begin
      if (accept) begin
        cnt       <= '0;
        req_write <= dbg_req_write;
        req_addr  <= dbg_req_addr;
        req_wdata <= dbg_req_wdata;
      end else if (state == DRAIN && cnt != 16'hffff) cnt <= cnt + 16'd1;
      if (timeout) begin
        dbg_rsp_rdata <= '0;
        dbg_rsp_err   <= 1'b1;
      end
      if (access && req_write) begin
        dbg_rsp_rdata <= '0;
        dbg_rsp_err   <= req_addr == '0;
      end
      if (state == CAPTURE) begin
        dbg_rsp_rdata <= rf_ra_rdata;
        dbg_rsp_err   <= 1'b0;
      end
    end
endmodule

// File: tb/tb_fwrisc_rf_dbg_arb.sv
// tb_fwrisc_rf_dbg_arb: directed bench with a registered-read regfile model (x0 reads zero), TIMEOUT=4.
module tb_fwrisc_rf_dbg_arb;
  logic clock = 1'b0;
  always #5 clock = ~clock;
  logic        reset = 1'b1;
  logic [5:0]  core_ra_raddr = '0, core_rd_waddr = '0;
  logic [31:0] core_rd_wdata = '0;
  logic        core_rd_wen = 1'b0, core_idle = 1'b0, core_stall;
  logic        dbg_req_valid = 1'b0, dbg_req_ready, dbg_req_write = 1'b0;
  logic [5:0]  dbg_req_addr = '0;
  logic [31:0] dbg_req_wdata = '0;
  logic        dbg_rsp_valid, dbg_rsp_ready = 1'b0, dbg_rsp_err;
  logic [31:0] dbg_rsp_rdata;
  logic [5:0]  rf_ra_raddr, rf_rd_waddr;
  logic [31:0] rf_rd_wdata, rf_ra_rdata;
  logic        rf_rd_wen;
  logic [31:0] mem [64];
  int          wen_pulses = 0;
  int          checks = 0, errors = 0;

  fwrisc_rf_dbg_arb #(.TIMEOUT(4)) dut (
    .clock(clock), .reset(reset),
    .core_ra_raddr(core_ra_raddr), .core_rd_waddr(core_rd_waddr),
    .core_rd_wdata(core_rd_wdata), .core_rd_wen(core_rd_wen),
    .core_idle(core_idle), .core_stall(core_stall),
    .dbg_req_valid(dbg_req_valid), .dbg_req_ready(dbg_req_ready),
    .dbg_req_write(dbg_req_write), .dbg_req_addr(dbg_req_addr),
    .dbg_req_wdata(dbg_req_wdata), .dbg_rsp_valid(dbg_rsp_valid),
    .dbg_rsp_ready(dbg_rsp_ready), .dbg_rsp_rdata(dbg_rsp_rdata),
    .dbg_rsp_err(dbg_rsp_err), .rf_ra_raddr(rf_ra_raddr),
    .rf_rd_waddr(rf_rd_waddr), .rf_rd_wdata(rf_rd_wdata),
    .rf_rd_wen(rf_rd_wen), .rf_ra_rdata(rf_ra_rdata)
  );

  always @(posedge clock) begin
    rf_ra_rdata <= (rf_ra_raddr == '0) ? 32'h0 : mem[rf_ra_raddr];
    if (rf_rd_wen) wen_pulses <= wen_pulses + 1;
    if (reset) for (int i = 0; i < 64; i++) mem[i] <= '0;
    else if (rf_rd_wen && rf_rd_waddr != '0) mem[rf_rd_waddr] <= rf_rd_wdata;
  end

  task tick();
    @(posedge clock);
    #1;
  endtask

  task accept_req(input logic w, input logic [5:0] a, input logic [31:0] d);
    dbg_req_valid = 1'b1; dbg_req_write = w; dbg_req_addr = a; dbg_req_wdata = d;
    #1;
    checks++;
    if (dbg_req_ready !== 1'b1) begin errors++; $display("FAIL req_ready_idle got %b want 1", dbg_req_ready); end
    tick();
    dbg_req_valid = 1'b0;
  endtask

  task finish_rsp();
    dbg_rsp_ready = 1'b1;
    tick();
    dbg_rsp_ready = 1'b0;
    #1;
    checks++;
    if (dbg_rsp_valid !== 1'b0 || dbg_req_ready !== 1'b1) begin
      errors++; $display("FAIL rsp_done valid=%b ready=%b want valid=0 ready=1", dbg_rsp_valid, dbg_req_ready);
    end
  endtask

  task do_read(input logic [5:0] a, input logic [31:0] exp);
    core_idle = 1'b1;
    accept_req(1'b0, a, 32'h0);
    tick(); tick(); tick();
    checks++;
    if (dbg_rsp_valid !== 1'b1 || dbg_rsp_rdata !== exp || dbg_rsp_err !== 1'b0) begin
      errors++; $display("FAIL read_x%0d valid=%b rdata=%h err=%b want 1 %h 0", a, dbg_rsp_valid, dbg_rsp_rdata, dbg_rsp_err, exp);
    end
    finish_rsp();
  endtask

  task test_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    #1;
    checks++;
    if (core_stall !== 1'b0 || dbg_req_ready !== 1'b1 || dbg_rsp_valid !== 1'b0) begin
      errors++; $display("FAIL reset_ctl stall=%b req_ready=%b rsp_valid=%b want 0 1 0", core_stall, dbg_req_ready, dbg_rsp_valid);
    end
    checks++;
    if (dbg_rsp_rdata !== 32'h0 || dbg_rsp_err !== 1'b0) begin
      errors++; $display("FAIL reset_rsp rdata=%h err=%b want 0 0", dbg_rsp_rdata, dbg_rsp_err);
    end
  endtask

  task test_passthrough();
    core_ra_raddr = 6'd12; core_rd_waddr = 6'd5; core_rd_wdata = 32'hDEADBEEF; core_rd_wen = 1'b1;
    #1;
    checks++;
    if (rf_ra_raddr !== 6'd12 || rf_rd_waddr !== 6'd5 || rf_rd_wdata !== 32'hDEADBEEF || rf_rd_wen !== 1'b1) begin
      errors++; $display("FAIL passthrough ra=%0d wa=%0d wd=%h wen=%b want 12 5 deadbeef 1", rf_ra_raddr, rf_rd_waddr, rf_rd_wdata, rf_rd_wen);
    end
    tick();
    core_rd_wen = 1'b0;
  endtask

  task test_read_x5();
    core_idle = 1'b1;
    accept_req(1'b0, 6'd5, 32'h0);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (core_stall !== 1'b1 || dbg_rsp_valid !== 1'b0) begin
        errors++; $display("FAIL read_stall_%0d stall=%b valid=%b want 1 0", i, core_stall, dbg_rsp_valid);
      end
      if (i == 1) begin
        checks++;
        if (rf_ra_raddr !== 6'd5) begin errors++; $display("FAIL access_raddr got %0d want 5", rf_ra_raddr); end
      end
      tick();
    end
    checks++;
    if (core_stall !== 1'b0 || dbg_rsp_valid !== 1'b1 || dbg_rsp_rdata !== 32'hDEADBEEF || dbg_rsp_err !== 1'b0) begin
      errors++; $display("FAIL read_rsp stall=%b valid=%b rdata=%h err=%b want 0 1 deadbeef 0", core_stall, dbg_rsp_valid, dbg_rsp_rdata, dbg_rsp_err);
    end
    checks++;
    if (dbg_req_ready !== 1'b0) begin errors++; $display("FAIL req_ready_resp got %b want 0", dbg_req_ready); end
    finish_rsp();
  endtask

  task test_write_read();
    int w0;
    w0 = wen_pulses;
    core_idle = 1'b1;
    accept_req(1'b1, 6'd3, 32'h12345678);
    tick();
    core_rd_wen = 1'b1; core_rd_waddr = 6'd9; core_rd_wdata = 32'hAAAA5555;
    #1;
    checks++;
    if (rf_rd_wen !== 1'b1 || rf_rd_waddr !== 6'd3 || rf_rd_wdata !== 32'h12345678) begin
      errors++; $display("FAIL access_write wen=%b wa=%0d wd=%h want 1 3 12345678", rf_rd_wen, rf_rd_waddr, rf_rd_wdata);
    end
    tick();
    core_rd_wen = 1'b0;
    checks++;
    if (dbg_rsp_valid !== 1'b1 || dbg_rsp_err !== 1'b0 || dbg_rsp_rdata !== 32'h0) begin
      errors++; $display("FAIL write_rsp valid=%b err=%b rdata=%h want 1 0 0", dbg_rsp_valid, dbg_rsp_err, dbg_rsp_rdata);
    end
    finish_rsp();
    checks++;
    if (wen_pulses - w0 !== 1 || mem[9] !== 32'h0) begin
      errors++; $display("FAIL write_pulses got %0d x9=%h want 1 0", wen_pulses - w0, mem[9]);
    end
    do_read(6'd3, 32'h12345678);
  endtask

  task test_write_x0();
    int w0;
    w0 = wen_pulses;
    core_idle = 1'b1;
    accept_req(1'b1, 6'd0, 32'hCAFEF00D);
    tick();
    checks++;
    if (rf_rd_wen !== 1'b0) begin errors++; $display("FAIL x0_wen got %b want 0", rf_rd_wen); end
    tick();
    checks++;
    if (dbg_rsp_valid !== 1'b1 || dbg_rsp_err !== 1'b1 || dbg_rsp_rdata !== 32'h0) begin
      errors++; $display("FAIL x0_rsp valid=%b err=%b rdata=%h want 1 1 0", dbg_rsp_valid, dbg_rsp_err, dbg_rsp_rdata);
    end
    finish_rsp();
    checks++;
    if (wen_pulses !== w0) begin errors++; $display("FAIL x0_pulses got %0d want 0", wen_pulses - w0); end
    do_read(6'd0, 32'h0);
  endtask

  task test_timeout();
    core_idle = 1'b0;
    accept_req(1'b0, 6'd5, 32'h0);
    for (int i = 0; i < 4; i++) begin
      if (i == 1) begin core_rd_wen = 1'b1; core_rd_waddr = 6'd7; core_rd_wdata = 32'h00000077; end
      #1;
      checks++;
      if (core_stall !== 1'b1 || dbg_rsp_valid !== 1'b0) begin
        errors++; $display("FAIL drain_%0d stall=%b valid=%b want 1 0", i, core_stall, dbg_rsp_valid);
      end
      if (i == 1) begin
        checks++;
        if (rf_rd_wen !== 1'b1 || rf_rd_waddr !== 6'd7) begin
          errors++; $display("FAIL drain_wb wen=%b wa=%0d want 1 7", rf_rd_wen, rf_rd_waddr);
        end
      end
      tick();
      core_rd_wen = 1'b0;
    end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (core_stall !== 1'b0 || dbg_rsp_valid !== 1'b1 || dbg_rsp_err !== 1'b1 || dbg_rsp_rdata !== 32'h0 || dbg_req_ready !== 1'b0) begin
        errors++; $display("FAIL timeout_hold_%0d stall=%b valid=%b err=%b rdata=%h rdy=%b want 0 1 1 0 0", i, core_stall, dbg_rsp_valid, dbg_rsp_err, dbg_rsp_rdata, dbg_req_ready);
      end
      tick();
    end
    finish_rsp();
    do_read(6'd7, 32'h00000077);
  endtask

  task test_hold_read();
    core_idle = 1'b1;
    accept_req(1'b0, 6'd5, 32'h0);
    tick(); tick(); tick();
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (dbg_rsp_valid !== 1'b1 || dbg_rsp_rdata !== 32'hDEADBEEF || dbg_req_ready !== 1'b0) begin
        errors++; $display("FAIL read_hold_%0d valid=%b rdata=%h rdy=%b want 1 deadbeef 0", i, dbg_rsp_valid, dbg_rsp_rdata, dbg_req_ready);
      end
      tick();
    end
    finish_rsp();
  endtask

  task test_idle_boundary();
    core_idle = 1'b0;
    accept_req(1'b0, 6'd3, 32'h0);
    tick(); tick(); tick();
    core_idle = 1'b1;
    tick();
    checks++;
    if (core_stall !== 1'b1 || dbg_rsp_valid !== 1'b0 || rf_ra_raddr !== 6'd3) begin
      errors++; $display("FAIL boundary_access stall=%b valid=%b ra=%0d want 1 0 3", core_stall, dbg_rsp_valid, rf_ra_raddr);
    end
    tick(); tick();
    checks++;
    if (dbg_rsp_valid !== 1'b1 || dbg_rsp_err !== 1'b0 || dbg_rsp_rdata !== 32'h12345678) begin
      errors++; $display("FAIL boundary_rsp valid=%b err=%b rdata=%h want 1 0 12345678", dbg_rsp_valid, dbg_rsp_err, dbg_rsp_rdata);
    end
    finish_rsp();
  endtask

  task test_reset_capture();
    core_idle = 1'b1;
    accept_req(1'b0, 6'd5, 32'h0);
    tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    checks++;
    if (dbg_rsp_valid !== 1'b0 || core_stall !== 1'b0 || dbg_req_ready !== 1'b1 || dbg_rsp_err !== 1'b0 || dbg_rsp_rdata !== 32'h0) begin
      errors++; $display("FAIL reset_capture valid=%b stall=%b rdy=%b err=%b rdata=%h want 0 0 1 0 0", dbg_rsp_valid, core_stall, dbg_req_ready, dbg_rsp_err, dbg_rsp_rdata);
    end
  endtask

  task test_reset_access();
    int w0;
    core_idle = 1'b1;
    accept_req(1'b1, 6'd4, 32'h55);
    tick();
    reset = 1'b1;
    #1;
    w0 = wen_pulses;
    checks++;
    if (rf_rd_wen !== 1'b0) begin errors++; $display("FAIL reset_access_wen got %b want 0", rf_rd_wen); end
    tick();
    reset = 1'b0;
    #1;
    checks++;
    if (wen_pulses !== w0 || dbg_rsp_valid !== 1'b0 || core_stall !== 1'b0) begin
      errors++; $display("FAIL reset_access pulses=%0d valid=%b stall=%b want 0 0 0", wen_pulses - w0, dbg_rsp_valid, core_stall);
    end
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_read_x5();
    test_write_read();
    test_write_x0();
    test_timeout();
    test_hold_read();
    test_idle_boundary();
    test_reset_capture();
    test_reset_access();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fwrisc_rf_dbg_arb.md
FWRISC_RF_DBG_ARB -- requirements
Module: fwrisc_rf_dbg_arb

Interface
REQ-001 Parameter TIMEOUT, default 255: max DRAIN cycles waiting for core_idle; legal range 1..65535.
REQ-002 clock  in  1  rising-edge clock.
REQ-003 reset  in  1  reset, synchronous, active-high.
REQ-004 core_ra_raddr  in  6  core read address.
REQ-005 core_rd_waddr / core_rd_wdata / core_rd_wen  in  6/32/1  core writeback port.
REQ-006 core_idle  in  1  core at instruction boundary, no writeback pending.
REQ-007 core_stall  out  1  core shall not fetch or issue while high.
REQ-008 dbg_req_valid / dbg_req_ready  in/out  1/1  debug request handshake.
REQ-009 dbg_req_write / dbg_req_addr / dbg_req_wdata  in  1/6/32  request: 1=write; regfile/CSR address; write data.
REQ-010 dbg_rsp_valid / dbg_rsp_ready  out/in  1/1  response handshake.
REQ-011 dbg_rsp_rdata / dbg_rsp_err  out  32/1  read data; error flag.
REQ-012 rf_ra_raddr / rf_rd_waddr / rf_rd_wdata / rf_rd_wen  out  6/6/32/1  to regfile.
REQ-013 rf_ra_rdata  in  32  regfile read data, registered, valid the cycle after its address is presented.

Function
REQ-014 States IDLE, DRAIN, ACCESS, CAPTURE, RESP; one-hot or encoded; no other reachable states.
REQ-015 dbg_req_ready = 1 only in IDLE; on valid&&ready: latch write/addr/wdata, clear timeout counter, go to DRAIN.
REQ-016 core_stall = 1 in DRAIN, ACCESS, CAPTURE; 0 in IDLE and RESP.
REQ-017 In all states except ACCESS, rf_* outputs equal core_* inputs combinationally (zero-latency pass-through).
REQ-018 DRAIN: core writebacks pass through; counter increments each cycle; core_idle=1 -> ACCESS next cycle.
REQ-019 DRAIN: counter == TIMEOUT-1 with core_idle=0 -> RESP with err=1, rdata=0, no regfile access.
REQ-020 core_idle=1 and counter==TIMEOUT-1 in same cycle: core_idle wins, go to ACCESS.
REQ-021 ACCESS (exactly 1 cycle): rf_ra_raddr = latched addr; on write with addr != 0: rf_rd_waddr = addr, rf_rd_wdata = wdata, rf_rd_wen = 1; else rf_rd_wen = 0.
REQ-022 ACCESS: core_rd_wen ignored (debug wins); core write that cycle is dropped.
REQ-023 Write to addr 0: no regfile write, err=1, rdata=0; ACCESS -> RESP.
REQ-024 Other writes: ACCESS -> RESP, err=0, rdata=0. Reads: ACCESS -> CAPTURE.
REQ-025 CAPTURE: latch rf_ra_rdata into dbg_rsp_rdata, err=0, -> RESP; read latency from acceptance = idle wait + 3 cycles to rsp_valid.
REQ-026 RESP: dbg_rsp_valid=1; rdata/err held stable until dbg_rsp_ready=1; on handshake -> IDLE.
REQ-027 dbg_rsp_valid = 0 outside RESP; next request accepted no earlier than the cycle after the response handshake.
REQ-028 Counter 16-bit, saturating; never wraps.

Reset
REQ-029 reset: state=IDLE, core_stall=0, dbg_req_ready=1 on first post-reset cycle, dbg_rsp_valid=0, dbg_rsp_rdata=0, dbg_rsp_err=0, counter=0, latched request cleared.
REQ-030 reset in any state aborts the operation; pending response discarded; no regfile write after reset asserts.

Verification
REQ-031 Read x5 (holds 0xDEADBEEF), core_idle=1 -> stall high 3 cycles; rsp_valid 4 cycles after acceptance; rdata=0xDEADBEEF, err=0.
REQ-032 Write addr 3 = 0x12345678, then read addr 3 -> rdata=0x12345678; rf_rd_wen high exactly 1 cycle.
REQ-033 Write addr 0 -> rf_rd_wen stays 0, err=1; subsequent read of addr 0 returns 0.
REQ-034 TIMEOUT=4, core_idle held 0 -> RESP after 4 DRAIN cycles, err=1, rdata=0, stall drops.
REQ-035 Core write x7 during DRAIN with core_idle=0 passes through; rsp_ready held 0 for 10 cycles -> rsp_valid/rdata stable; req_ready stays 0.
REQ-036 reset asserted in CAPTURE -> next cycle IDLE, rsp_valid=0, stall=0, req_ready=1.
